// File: rtl/lifo_arbiter.sv
// rtl/lifo_arbiter.sv - two-requester round-robin arbiter fronting a LIFO stack
// Optional grant counters enabled by defining LIFO_ARB_STATS_EN.
module lifo_arbiter #(
   parameter int WIDTH        = 16,
   parameter int REQ_HOLD_MAX = 15
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             rw0,
   input  logic             rw1,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             err,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] st_dataIn,
   output logic             st_RW,
   output logic             st_EN,
   input  logic [WIDTH-1:0] st_dataOut,
   input  logic             st_EMPTY,
   input  logic             st_FULL,
   output logic [15:0]      gcnt0,
   output logic [15:0]      gcnt1
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   localparam int WW = $clog2(REQ_HOLD_MAX + 2);

   state_t           state, state_nxt;
   logic             win_q, op_q, last_gnt, sel, legal;
   logic [WIDTH-1:0] data_q;
   logic [WW-1:0]    wait0, wait1;
   logic             starve0, starve1;

   assign starve0 = (wait0 >= WW'(REQ_HOLD_MAX));
   assign starve1 = (wait1 >= WW'(REQ_HOLD_MAX));
   assign legal   = op_q ? !st_EMPTY : !st_FULL;

   // Starvation overrides the round-robin pointer; a tie falls back to it.
   always_comb begin
      sel = ~last_gnt;
      if (req0 && !req1)
         sel = 1'b0;
      else if (req1 && !req0)
         sel = 1'b1;
      else if (starve0 && !starve1)
         sel = 1'b0;
      else if (starve1 && !starve0)
         sel = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      err       = 1'b0;
      st_EN     = 1'b0;
      st_RW     = 1'b0;
      st_dataIn = '0;
      case (state)
         IDLE: begin
            if (req0 || req1)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            gnt0      = !win_q;
            gnt1      = win_q;
            err       = !legal;
            st_EN     = legal;
            st_RW     = legal && op_q;
            st_dataIn = legal ? data_q : '0;
            state_nxt = (legal && op_q) ? CAPTURE : IDLE;
         end
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         wait0    <= '0;
         wait1    <= '0;
         win_q    <= 1'b0;
         op_q     <= 1'b0;
         data_q   <= '0;
         rdata    <= '0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
      end else begin
         state   <= state_nxt;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (state == IDLE && (req0 || req1)) begin
            win_q  <= sel;
            op_q   <= sel ? rw1 : rw0;
            data_q <= sel ? din1 : din0;
            wait0  <= (req0 && sel) ? (starve0 ? wait0 : wait0 + WW'(1)) : '0;
            wait1  <= (req1 && !sel) ? (starve1 ? wait1 : wait1 + WW'(1)) : '0;
         end
         if (state == ISSUE)
            last_gnt <= win_q;
         if (state == CAPTURE) begin
            rdata   <= st_dataOut;
            rvalid0 <= !win_q;
            rvalid1 <= win_q;
         end
      end
   end

`ifdef LIFO_ARB_STATS_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         gcnt0 <= '0;
         gcnt1 <= '0;
      end else begin
         if (gnt0 && gcnt0 != 16'hFFFF)
            gcnt0 <= gcnt0 + 16'd1;
         if (gnt1 && gcnt1 != 16'hFFFF)
            gcnt1 <= gcnt1 + 16'd1;
      end
   end
`else
   assign gcnt0 = '0;
   assign gcnt1 = '0;
`endif

endmodule
